// File: rtl/cabac_byte_writer.sv
// CABAC encoder byte-output stage: buffers the last lead byte plus a run of 0xFF bytes
// until the carry is known, then streams resolved bytes on a ready/valid interface.
module cabac_byte_writer #(
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_lead_valid,
  output logic             o_lead_ready,
  input  logic [8:0]       i_lead_byte,
  input  logic             i_flush_valid,
  input  logic             i_flush_carry,
  output logic             o_flush_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [7:0]       o_out_byte,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pending_cnt,
  output logic             o_overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT_BUF,
    S_EMIT_RUN,
    S_FLUSH_BUF,
    S_FLUSH_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           r_state;
  logic [7:0]       r_buffered;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] r_run_left;
  logic [7:0]       r_runbyte;
  logic             r_out_valid;
  logic [7:0]       r_out_byte;
  logic             r_done;
  logic             r_overflow;

  state_t           w_state_nxt;
  logic [7:0]       w_buffered_nxt;
  logic [CNT_W-1:0] w_pending_nxt;
  logic [CNT_W-1:0] w_run_left_nxt;
  logic [7:0]       w_runbyte_nxt;
  logic             w_out_valid_nxt;
  logic [7:0]       w_out_byte_nxt;
  logic             w_done_nxt;
  logic             w_overflow_nxt;

  logic             w_idle;
  logic             w_lead_acc;
  logic             w_flush_acc;
  logic             w_hs;
  logic             w_lead_c;
  logic [7:0]       w_lead_b;

  assign w_idle      = (r_state == S_IDLE);
  assign w_lead_acc  = i_lead_valid & w_idle;
  assign w_flush_acc = i_flush_valid & w_idle & ~i_lead_valid;
  assign w_hs        = r_out_valid & i_out_ready;
  assign w_lead_c    = i_lead_byte[8];
  assign w_lead_b    = i_lead_byte[7:0];

  assign o_lead_ready  = w_idle;
  assign o_flush_ready = w_idle & ~i_lead_valid;
  assign o_out_valid   = r_out_valid;
  assign o_out_byte    = r_out_byte;
  assign o_done        = r_done;
  assign o_pending_cnt = r_pending;
  assign o_overflow    = r_overflow;

  always_comb begin
    w_state_nxt     = r_state;
    w_buffered_nxt  = r_buffered;
    w_pending_nxt   = r_pending;
    w_run_left_nxt  = r_run_left;
    w_runbyte_nxt   = r_runbyte;
    w_out_valid_nxt = r_out_valid;
    w_out_byte_nxt  = r_out_byte;
    w_done_nxt      = 1'b0;
    w_overflow_nxt  = r_overflow;

    case (r_state)
      S_IDLE: begin
        if (w_lead_acc) begin
          if (i_lead_byte == 9'h0FF) begin
            if (r_pending == CNT_MAX) begin
              w_overflow_nxt = 1'b1;
            end else begin
              w_pending_nxt = r_pending + CNT_ONE;
            end
          end else if (r_pending != CNT_ZERO) begin
            // Carry is now known: release the buffered byte, the 0xFF run follows.
            w_out_byte_nxt  = r_buffered + {7'd0, w_lead_c};
            w_out_valid_nxt = 1'b1;
            w_run_left_nxt  = r_pending - CNT_ONE;
            w_runbyte_nxt   = {8{~w_lead_c}};
            w_buffered_nxt  = w_lead_b;
            w_pending_nxt   = CNT_ONE;
            w_state_nxt     = S_EMIT_BUF;
          end else begin
            w_buffered_nxt = w_lead_b;
            w_pending_nxt  = CNT_ONE;
          end
        end else if (w_flush_acc) begin
          if (r_pending == CNT_ZERO) begin
            w_state_nxt = S_DONE;
          end else begin
            w_out_byte_nxt  = r_buffered + {7'd0, i_flush_carry};
            w_out_valid_nxt = 1'b1;
            w_run_left_nxt  = r_pending - CNT_ONE;
            w_runbyte_nxt   = {8{~i_flush_carry}};
            w_state_nxt     = S_FLUSH_BUF;
          end
        end
      end

      S_EMIT_BUF, S_FLUSH_BUF: begin
        if (w_hs) begin
          if (r_run_left != CNT_ZERO) begin
            w_out_byte_nxt = r_runbyte;
            w_state_nxt    = (r_state == S_EMIT_BUF) ? S_EMIT_RUN : S_FLUSH_RUN;
          end else begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = (r_state == S_EMIT_BUF) ? S_IDLE : S_DONE;
          end
        end
      end

      S_EMIT_RUN, S_FLUSH_RUN: begin
        if (w_hs) begin
          if (r_run_left <= CNT_ONE) begin
            w_out_valid_nxt = 1'b0;
            w_run_left_nxt  = CNT_ZERO;
            w_state_nxt     = (r_state == S_EMIT_RUN) ? S_IDLE : S_DONE;
          end else begin
            w_run_left_nxt = r_run_left - CNT_ONE;
          end
        end
      end

      S_DONE: begin
        w_done_nxt     = 1'b1;
        w_buffered_nxt = 8'hFF;
        w_pending_nxt  = CNT_ZERO;
        w_state_nxt    = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_buffered  <= 8'hFF;
      r_pending   <= CNT_ZERO;
      r_run_left  <= CNT_ZERO;
      r_runbyte   <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_buffered  <= w_buffered_nxt;
      r_pending   <= w_pending_nxt;
      r_run_left  <= w_run_left_nxt;
      r_runbyte   <= w_runbyte_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_byte  <= w_out_byte_nxt;
      r_done      <= w_done_nxt;
      r_overflow  <= w_overflow_nxt;
    end
  end

endmodule

// File: tb/tb_cabac_byte_writer.sv
// Testbench for cabac_byte_writer: table-driven lead sequences plus hand-written
// stall, flush, overflow and reset sequences; output bytes go through a scoreboard queue.
module tb_cabac_byte_writer;

  localparam int TB_CNT_W = 3;

  typedef struct {
    logic              rst;
    logic [8:0]        lead;
    int                n;
    logic [3:0][7:0]   exp;
    logic [TB_CNT_W-1:0] pend;
  } vec_t;

  logic                i_clk;
  logic                i_rst;
  logic                i_lead_valid;
  logic                o_lead_ready;
  logic [8:0]          i_lead_byte;
  logic                i_flush_valid;
  logic                i_flush_carry;
  logic                o_flush_ready;
  logic                o_out_valid;
  logic                i_out_ready;
  logic [7:0]          o_out_byte;
  logic                o_done;
  logic [TB_CNT_W-1:0] o_pending_cnt;
  logic                o_overflow;

  int         checks;
  int         failures;
  int         doneCount;
  logic [7:0] expQ[$];
  logic [7:0] expByte;
  vec_t       vecs[$];

  cabac_byte_writer #(.CNT_W(TB_CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_lead_valid (i_lead_valid),
    .o_lead_ready (o_lead_ready),
    .i_lead_byte  (i_lead_byte),
    .i_flush_valid(i_flush_valid),
    .i_flush_carry(i_flush_carry),
    .o_flush_ready(o_flush_ready),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_byte   (o_out_byte),
    .o_done       (o_done),
    .o_pending_cnt(o_pending_cnt),
    .o_overflow   (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every handshaken byte must match the oldest expected byte.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_done) doneCount++;
      if (o_out_valid && i_out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", o_out_byte);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("out_byte", 32'(o_out_byte), 32'(expByte));
        end
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_rst         = 1'b1;
    i_lead_valid  = 1'b0;
    i_flush_valid = 1'b0;
    i_flush_carry = 1'b0;
    i_lead_byte   = 9'h000;
    i_out_ready   = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    expQ.delete();
    doneCount = 0;
  endtask

  task automatic applyStimulus(input string name, input logic [8:0] lead, input int nexp,
                               input logic [3:0][7:0] exp, input logic [TB_CNT_W-1:0] pend);
    int g;
    int busy;
    g = 0;
    while (!o_lead_ready && g < 50) begin
      step();
      g++;
    end
    if (g >= 50) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_ready_timeout: got lead_ready=0, expected 1", name);
    end
    for (int k = 0; k < nexp; k++) expQ.push_back(exp[k]);
    i_lead_valid = 1'b1;
    i_lead_byte  = lead;
    step();
    i_lead_valid = 1'b0;
    checkOutput({name, "_latency"}, 32'(o_out_valid), 32'(nexp > 0));
    busy = 0;
    while (!o_lead_ready && busy < 100) begin
      step();
      busy++;
    end
    checkOutput({name, "_busy_cycles"}, 32'(busy), 32'(nexp));
    checkOutput({name, "_pending"}, 32'(o_pending_cnt), 32'(pend));
    checkOutput({name, "_queue"}, 32'(expQ.size()), 32'd0);
  endtask

  task automatic applyFlush(input string name, input logic carry, input int nexp,
                            input logic [3:0][7:0] exp);
    int g;
    g = 0;
    while (!o_flush_ready && g < 50) begin
      step();
      g++;
    end
    for (int k = 0; k < nexp; k++) expQ.push_back(exp[k]);
    doneCount     = 0;
    i_flush_valid = 1'b1;
    i_flush_carry = carry;
    step();
    i_flush_valid = 1'b0;
    checkOutput({name, "_latency"}, 32'(o_out_valid), 32'(nexp > 0));
    g = 0;
    while (doneCount == 0 && g < 100) begin
      step();
      g++;
    end
    step();
    step();
    checkOutput({name, "_done_count"}, 32'(doneCount), 32'd1);
    checkOutput({name, "_pending"}, 32'(o_pending_cnt), 32'd0);
    checkOutput({name, "_queue"}, 32'(expQ.size()), 32'd0);
  endtask

  function automatic vec_t mk(input logic r, input logic [8:0] l, input int n,
                              input logic [31:0] e, input logic [TB_CNT_W-1:0] p);
    vec_t v;
    v.rst  = r;
    v.lead = l;
    v.n    = n;
    v.exp  = e;
    v.pend = p;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int g;
    checks    = 0;
    failures  = 0;
    doneCount = 0;

    vecs.push_back(mk(1'b1, 9'h012, 0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b0, 9'h034, 1, 32'h0000_0012, 3'd1));
    vecs.push_back(mk(1'b1, 9'h012, 0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b0, 9'h0FF, 0, 32'h0, 3'd2));
    vecs.push_back(mk(1'b0, 9'h0FF, 0, 32'h0, 3'd3));
    vecs.push_back(mk(1'b0, 9'h105, 3, 32'h0000_0013, 3'd1));
    vecs.push_back(mk(1'b1, 9'h012, 0, 32'h0, 3'd1));
    vecs.push_back(mk(1'b0, 9'h0FF, 0, 32'h0, 3'd2));
    vecs.push_back(mk(1'b0, 9'h0FF, 0, 32'h0, 3'd3));
    vecs.push_back(mk(1'b0, 9'h005, 3, 32'h00FF_FF12, 3'd1));
    vecs.push_back(mk(1'b0, 9'h1FF, 1, 32'h0000_0006, 3'd1));
    vecs.push_back(mk(1'b0, 9'h100, 1, 32'h0000_0000, 3'd1));
    vecs.push_back(mk(1'b0, 9'h0FF, 0, 32'h0, 3'd2));
    vecs.push_back(mk(1'b0, 9'h0FF, 0, 32'h0, 3'd3));
    vecs.push_back(mk(1'b0, 9'h0FF, 0, 32'h0, 3'd4));
    vecs.push_back(mk(1'b0, 9'h107, 4, 32'h0000_0001, 3'd1));
    vecs.push_back(mk(1'b0, 9'h0FF, 0, 32'h0, 3'd2));
    vecs.push_back(mk(1'b0, 9'h04A, 2, 32'h0000_FF07, 3'd1));

    // Reset values.
    doReset();
    checkOutput("reset_out_valid", 32'(o_out_valid), 32'd0);
    checkOutput("reset_out_byte", 32'(o_out_byte), 32'd0);
    checkOutput("reset_done", 32'(o_done), 32'd0);
    checkOutput("reset_pending", 32'(o_pending_cnt), 32'd0);
    checkOutput("reset_overflow", 32'(o_overflow), 32'd0);
    checkOutput("reset_lead_ready", 32'(o_lead_ready), 32'd1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) doReset();
      applyStimulus($sformatf("vec%0d", i), vecs[i].lead, vecs[i].n, vecs[i].exp, vecs[i].pend);
    end

    // Backpressure on the second byte of a carry-resolved run.
    doReset();
    applyStimulus("stall_pre0", 9'h012, 0, 32'h0, 3'd1);
    applyStimulus("stall_pre1", 9'h0FF, 0, 32'h0, 3'd2);
    applyStimulus("stall_pre2", 9'h0FF, 0, 32'h0, 3'd3);
    expQ.push_back(8'h13);
    expQ.push_back(8'h00);
    expQ.push_back(8'h00);
    i_lead_valid = 1'b1;
    i_lead_byte  = 9'h105;
    step();
    i_lead_valid = 1'b0;
    step();
    i_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("stall_byte", 32'(o_out_byte), 32'h00);
      checkOutput("stall_valid", 32'(o_out_valid), 32'd1);
      checkOutput("stall_lead_ready", 32'(o_lead_ready), 32'd0);
    end
    checkOutput("stall_queue_mid", 32'(expQ.size()), 32'd2);
    i_out_ready = 1'b1;
    g = 0;
    while (!o_lead_ready && g < 50) begin
      step();
      g++;
    end
    checkOutput("stall_queue_end", 32'(expQ.size()), 32'd0);
    checkOutput("stall_pending", 32'(o_pending_cnt), 32'd1);

    // Flush with carry through a buffered 0xFF, then a carry-free flush.
    doReset();
    applyStimulus("fl1_pre0", 9'h0FF, 0, 32'h0, 3'd1);
    applyStimulus("fl1_pre1", 9'h0FF, 0, 32'h0, 3'd2);
    applyFlush("flush_carry1", 1'b1, 2, 32'h0000_0000);
    applyStimulus("fl2_pre0", 9'h012, 0, 32'h0, 3'd1);
    applyStimulus("fl2_pre1", 9'h0FF, 0, 32'h0, 3'd2);
    applyFlush("flush_carry0", 1'b0, 2, 32'h0000_FF12);

    // Empty flush: done two cycles after acceptance, exactly once.
    doReset();
    i_flush_valid = 1'b1;
    step();
    i_flush_valid = 1'b0;
    checkOutput("empty_flush_done_t1", 32'(o_done), 32'd0);
    checkOutput("empty_flush_lead_ready", 32'(o_lead_ready), 32'd0);
    step();
    checkOutput("empty_flush_done_t2", 32'(o_done), 32'd1);
    step();
    checkOutput("empty_flush_done_t3", 32'(o_done), 32'd0);
    checkOutput("empty_flush_pending", 32'(o_pending_cnt), 32'd0);

    // Counter saturation and sticky overflow.
    doReset();
    applyStimulus("ovf_lead", 9'h001, 0, 32'h0, 3'd1);
    for (int k = 0; k < 6; k++)
      applyStimulus($sformatf("ovf_ff%0d", k), 9'h0FF, 0, 32'h0, 3'(k + 2));
    checkOutput("ovf_before", 32'(o_overflow), 32'd0);
    applyStimulus("ovf_ff6", 9'h0FF, 0, 32'h0, 3'd7);
    applyStimulus("ovf_ff7", 9'h0FF, 0, 32'h0, 3'd7);
    checkOutput("ovf_set", 32'(o_overflow), 32'd1);
    for (int k = 0; k < 6; k++) expQ.push_back(8'hFF);
    expQ.push_front(8'h01);
    i_lead_valid = 1'b1;
    i_lead_byte  = 9'h005;
    step();
    i_lead_valid = 1'b0;
    g = 0;
    while (!o_lead_ready && g < 50) begin
      step();
      g++;
    end
    checkOutput("ovf_release_queue", 32'(expQ.size()), 32'd0);
    checkOutput("ovf_sticky", 32'(o_overflow), 32'd1);
    doReset();
    checkOutput("ovf_cleared", 32'(o_overflow), 32'd0);

    // Lead and flush presented together: lead wins, flush follows.
    i_lead_valid  = 1'b1;
    i_lead_byte   = 9'h022;
    i_flush_valid = 1'b1;
    i_flush_carry = 1'b0;
    #1;
    checkOutput("both_flush_ready", 32'(o_flush_ready), 32'd0);
    checkOutput("both_lead_ready", 32'(o_lead_ready), 32'd1);
    step();
    i_lead_valid = 1'b0;
    checkOutput("both_pending_after_lead", 32'(o_pending_cnt), 32'd1);
    checkOutput("both_no_output", 32'(o_out_valid), 32'd0);
    expQ.push_back(8'h22);
    doneCount = 0;
    step();
    i_flush_valid = 1'b0;
    checkOutput("both_flush_byte_valid", 32'(o_out_valid), 32'd1);
    g = 0;
    while (doneCount == 0 && g < 50) begin
      step();
      g++;
    end
    checkOutput("both_done_count", 32'(doneCount), 32'd1);
    checkOutput("both_queue", 32'(expQ.size()), 32'd0);

    // Reset while a byte is stalled discards it and the pending state.
    doReset();
    applyStimulus("rst_pre0", 9'h012, 0, 32'h0, 3'd1);
    i_out_ready  = 1'b0;
    i_lead_valid = 1'b1;
    i_lead_byte  = 9'h034;
    step();
    i_lead_valid = 1'b0;
    step();
    checkOutput("rst_mid_valid_before", 32'(o_out_valid), 32'd1);
    i_rst = 1'b1;
    step();
    checkOutput("rst_mid_out_valid", 32'(o_out_valid), 32'd0);
    checkOutput("rst_mid_out_byte", 32'(o_out_byte), 32'd0);
    checkOutput("rst_mid_pending", 32'(o_pending_cnt), 32'd0);
    i_rst       = 1'b0;
    i_out_ready = 1'b1;
    expQ.delete();
    for (int k = 0; k < 4; k++) step();
    checkOutput("rst_mid_lead_ready", 32'(o_lead_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
